// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a WIDTH-bit payload as start bit, data bits (LSB first),
// optional parity bit and one or two stop bits, each bit lasting CLKS_PER_BIT clocks.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   tx_valid_i   frame request
//   tx_data_i    payload
//   par_en_i     1 inserts a parity bit
//   par_odd_i    1 odd parity, 0 even parity
//   stop2_i      1 two stop bits, 0 one stop bit
//   tx_ready_o   ready to accept a frame (IDLE only)
//   tx_o         registered serial line, idle high
//   busy_o       frame in progress
//   load_bit_o   1-cycle pulse following acceptance, loads the parity generator
//   frame_done_o 1-cycle pulse on the final cycle of the stop period
module uart_tx_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             par_en_i,
  input  logic             par_odd_i,
  input  logic             stop2_i,
  output logic             tx_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             load_bit_o,
  output logic             frame_done_o
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               par_en_q, par_en_d;
  logic               par_odd_q, par_odd_d;
  logic               stop2_q, stop2_d;
  logic               tx_q, tx_d;
  logic               load_bit_q, load_bit_d;
  logic               baud_end;

  assign baud_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    load_bit_d = 1'b0;
    tx_d       = 1'b1;

    // Baud counter free-runs while a frame is in flight and wraps on every bit boundary.
    if (state_q != StIdle) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid_i) begin
          state_d    = StStart;
          baud_d     = '0;
          bit_d      = '0;
          stop_cnt_d = 1'b0;
          data_d     = tx_data_i;
          par_en_d   = par_en_i;
          par_odd_d  = par_odd_i;
          stop2_d    = stop2_i;
          load_bit_d = 1'b1;
        end
      end
      StStart: begin
        if (baud_end) state_d = StData;
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == BitW'(WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (baud_end) state_d = StStop;
      end
      StStop: begin
        if (baud_end) begin
          // With two stop bits the first boundary only advances the stop counter.
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is derived from the next state so the register holds the level of the coming cycle.
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_d];
      StParity: tx_d = (^data_d) ^ par_odd_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      load_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      load_bit_q <= load_bit_d;
    end
  end

  assign tx_ready_o   = (state_q == StIdle);
  assign busy_o       = ~tx_ready_o;
  assign tx_o         = tx_q;
  assign load_bit_o   = load_bit_q;
  assign frame_done_o = (state_q == StStop) & baud_end & (~stop2_q | stop_cnt_q);

endmodule
